// File: rtl/uart_rx_ext_if.sv
// Receiver bundle: serial line and ack into the receiver, held word plus status out.
interface uart_rx_ext_if #(
  parameter int DATA_BITS = 8
);
  logic                 uart_rx;
  logic                 rx_ack;
  logic                 rx_valid;
  logic [DATA_BITS-1:0] rx_data;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun;

  modport slave  (input  uart_rx, rx_ack,
                  output rx_valid, rx_data, parity_err, frame_err, overrun);
  modport master (output uart_rx, rx_ack,
                  input  rx_valid, rx_data, parity_err, frame_err, overrun);
endinterface

// File: rtl/uart_rx_ext.sv
// Oversampling UART receiver: 2-flop synchroniser, 3-sample majority per bit,
// false-start rejection, parity/framing/overrun flags and a valid/ack output register.
module uart_rx_ext #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic         bot_clk,
  input  logic         reset,
  uart_rx_ext_if.slave rx
);
  localparam int M  = OVERSAMPLE / 2;
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] T_LO  = TW'(M - 1);
  localparam logic [TW-1:0] T_MID = TW'(M);
  localparam logic [TW-1:0] T_HI  = TW'(M + 1);
  localparam logic [TW-1:0] T_END = TW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_BRK} state_t;

  typedef struct packed {
    logic [DATA_BITS-1:0] data;
    logic                 perr;
    logic                 ferr;
  } rx_word_t;

  // Synchroniser. sync_fill marks when rxs carries a genuine line sample rather
  // than its reset value, so a line held low through reset never arms.
  logic       rx_meta, rxs, rxs_d, armed;
  logic [1:0] sync_fill;

  always_ff @(posedge bot_clk or negedge reset)
    if (!reset) begin
      rx_meta   <= 1'b1;
      rxs       <= 1'b1;
      rxs_d     <= 1'b1;
      sync_fill <= '0;
      armed     <= 1'b0;
    end else begin
      rx_meta   <= rx.uart_rx;
      rxs       <= rx_meta;
      rxs_d     <= rxs;
      sync_fill <= {sync_fill[0], 1'b1};
      if (sync_fill[1] && rxs) armed <= 1'b1;
    end

  state_t               state;
  logic [TW-1:0]        tick;
  logic                 s0, s1, maj;
  logic                 decide, wrap, done;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_acc, perr_q, ferr_q;
  rx_word_t             word, held;
  logic                 valid_q, ovr_q;

  assign maj    = (s0 & s1) | (s0 & rxs) | (s1 & rxs);
  assign decide = (tick == T_HI);
  assign wrap   = (tick == T_END);
  // Frame ends at the decision point of the last stop bit, not at its end.
  assign done   = (state == S_STOP) && decide && (bit_cnt == BW'(STOP_BITS - 1));
  assign word   = {shreg, perr_q, ferr_q | ~maj};

  always_ff @(posedge bot_clk or negedge reset)
    if (!reset) begin
      state   <= S_IDLE;
      tick    <= '0;
      s0      <= 1'b1;
      s1      <= 1'b1;
      bit_cnt <= '0;
      shreg   <= '0;
      par_acc <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      tick <= wrap ? '0 : tick + 1'b1;
      if (tick == T_LO)  s0 <= rxs;
      if (tick == T_MID) s1 <= rxs;
      case (state)
        S_IDLE: begin
          tick <= '0;
          // the detect cycle itself is tick 0 of the start bit
          if (armed && rxs_d && !rxs) begin
            state <= S_START;
            tick  <= TW'(1);
          end
        end
        S_START: begin
          if (decide && maj) begin
            state <= S_IDLE;
          end else if (wrap) begin
            state   <= S_DATA;
            bit_cnt <= '0;
            par_acc <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
          end
        end
        S_DATA: begin
          if (decide) begin
            shreg   <= {maj, shreg[DATA_BITS-1:1]};
            par_acc <= par_acc ^ maj;
            bit_cnt <= bit_cnt + 1'b1;
          end
          if (wrap && bit_cnt == BW'(DATA_BITS)) begin
            state   <= (PARITY != 0) ? S_PAR : S_STOP;
            bit_cnt <= '0;
          end
        end
        S_PAR: begin
          if (decide) perr_q <= (PARITY == 1) ? ~(par_acc ^ maj) : (par_acc ^ maj);
          if (wrap) state <= S_STOP;
        end
        S_STOP: begin
          if (decide) begin
            if (!maj) ferr_q <= 1'b1;
            if (bit_cnt == BW'(STOP_BITS - 1)) begin
              state <= maj ? S_IDLE : S_BRK;
              tick  <= '0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        S_BRK: begin
          tick <= '0;
          if (rxs) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end

  // Output register: newest word always wins; ack clears flags but keeps data.
  always_ff @(posedge bot_clk or negedge reset)
    if (!reset) begin
      held    <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else if (done) begin
      held    <= word;
      valid_q <= 1'b1;
      ovr_q   <= valid_q & ~rx.rx_ack;
    end else if (valid_q && rx.rx_ack) begin
      valid_q   <= 1'b0;
      ovr_q     <= 1'b0;
      held.perr <= 1'b0;
      held.ferr <= 1'b0;
    end

  assign rx.rx_valid   = valid_q;
  assign rx.rx_data    = held.data;
  assign rx.parity_err = held.perr;
  assign rx.frame_err  = held.ferr;
  assign rx.overrun    = ovr_q;
endmodule

// File: tb/tb_uart_rx_ext.sv
// Bench for uart_rx_ext: four configurations driven with directed and random frames,
// checked every cycle against a frame-level expectation queue plus literal spot checks.
module tb_uart_rx_ext;
  localparam int NI = 4;
  localparam int DBA [NI] = '{8, 8, 9, 5};
  localparam int OSA [NI] = '{16, 16, 8, 8};
  localparam int PAA [NI] = '{0, 2, 1, 0};
  localparam int SBA [NI] = '{1, 1, 2, 2};

  logic bot_clk = 1'b0;
  logic reset   = 1'b0;
  always #5 bot_clk = ~bot_clk;

  logic [NI-1:0]      pin, ack;
  logic [NI-1:0]      o_valid, o_perr, o_ferr, o_ovr;
  logic [NI-1:0][8:0] o_data;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    uart_rx_ext_if #(.DATA_BITS(DBA[g])) bus ();
    assign bus.uart_rx = pin[g];
    assign bus.rx_ack  = ack[g];
    assign o_valid[g]  = bus.rx_valid;
    assign o_perr[g]   = bus.parity_err;
    assign o_ferr[g]   = bus.frame_err;
    assign o_ovr[g]    = bus.overrun;
    assign o_data[g]   = 9'(bus.rx_data);
    uart_rx_ext #(.DATA_BITS(DBA[g]), .OVERSAMPLE(OSA[g]), .PARITY(PAA[g]), .STOP_BITS(SBA[g]))
      dut (.bot_clk(bot_clk), .reset(reset), .rx(bus.slave));
  end

  int cyc = 0;
  always @(posedge bot_clk) cyc <= cyc + 1;

  typedef struct {
    int         inst;
    int         vis;   // first cycle the word must be visible
    logic [8:0] data;
    bit         perr;
    bit         ferr;
  } ev_t;
  ev_t evq[$];

  bit         m_valid [NI], m_perr [NI], m_ferr [NI], m_ovr [NI], prev_v [NI];
  logic [8:0] m_data  [NI];
  int         rise_cyc[NI];
  int         total = 0, bad = 0;
  int         c0;
  bit         rnd_done;

  // Cycles from the pin going low to rx_valid: 2 synchroniser + (N-1) bits + M + 2.
  function automatic int lat(int i);
    int n;
    n = 1 + DBA[i] + ((PAA[i] != 0) ? 1 : 0) + SBA[i];
    return 4 + (n - 1) * OSA[i] + OSA[i] / 2;
  endfunction

  always @(negedge bot_clk) begin : cmp
    int k;
    for (int i = 0; i < NI; i++) begin
      if (!reset) begin
        m_valid[i] = 0; m_perr[i] = 0; m_ferr[i] = 0; m_ovr[i] = 0; m_data[i] = '0;
        for (int j = evq.size() - 1; j >= 0; j--) if (evq[j].inst == i) evq.delete(j);
      end
      total++;
      if ({o_valid[i], o_ovr[i], o_perr[i], o_ferr[i], o_data[i]} !==
          {m_valid[i], m_ovr[i], m_perr[i], m_ferr[i], m_data[i]}) begin
        bad++;
        $display("FAIL outputs inst%0d cyc%0d: got v=%0b ov=%0b pe=%0b fe=%0b d=%h, want v=%0b ov=%0b pe=%0b fe=%0b d=%h",
                 i, cyc, o_valid[i], o_ovr[i], o_perr[i], o_ferr[i], o_data[i],
                 m_valid[i], m_ovr[i], m_perr[i], m_ferr[i], m_data[i]);
      end
      if (o_valid[i] && !prev_v[i]) rise_cyc[i] = cyc;
      prev_v[i] = o_valid[i];
      if (reset) begin
        k = -1;
        foreach (evq[j]) if (evq[j].inst == i && evq[j].vis == cyc + 1) k = j;
        if (k >= 0) begin
          m_ovr[i]   = m_valid[i] && !ack[i];
          m_valid[i] = 1;
          m_data[i]  = evq[k].data;
          m_perr[i]  = evq[k].perr;
          m_ferr[i]  = evq[k].ferr;
          evq.delete(k);
        end else if (m_valid[i] && ack[i]) begin
          m_valid[i] = 0; m_ovr[i] = 0; m_perr[i] = 0; m_ferr[i] = 0;
        end
      end
    end
  end

  task automatic check(string name, int got, int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, got, got, want, want);
    end
  endtask

  task automatic tick(int n);
    repeat (n) begin @(posedge bot_clk); #1; end
  endtask

  task automatic line(int i, bit v, int n);
    pin[i] = v;
    tick(n);
  endtask

  task automatic pulse_ack(int i);
    ack[i] = 1'b1;
    tick(1);
    ack[i] = 1'b0;
  endtask

  // Sends one frame on instance i, start bit beginning in the current cycle.
  // corrupt flips one sample inside each bit's voting window.
  task automatic send(int i, int data, bit par_ok, int stop_mask, bit corrupt);
    bit   bits[$];
    ev_t  e;
    int   ones, cpos;
    bit   pbit, ferr;
    bits.push_back(1'b0);
    for (int b = 0; b < DBA[i]; b++) bits.push_back(data[b]);
    if (PAA[i] != 0) begin
      ones = $countones(data & ((1 << DBA[i]) - 1));
      pbit = (PAA[i] == 1) ? (ones % 2 == 0) : (ones % 2 == 1);
      bits.push_back(par_ok ? pbit : !pbit);
    end
    ferr = 0;
    for (int s = 0; s < SBA[i]; s++) begin
      bits.push_back(stop_mask[s]);
      if (!stop_mask[s]) ferr = 1;
    end
    e.inst = i;
    e.vis  = cyc + lat(i);
    e.data = 9'(data & ((1 << DBA[i]) - 1));
    e.perr = (PAA[i] != 0) && !par_ok;
    e.ferr = ferr;
    evq.push_back(e);
    foreach (bits[b]) begin
      cpos = $urandom_range(OSA[i] / 2 - 1, OSA[i] / 2 + 1);
      for (int t = 0; t < OSA[i]; t++) begin
        pin[i] = (corrupt && t == cpos) ? !bits[b] : bits[b];
        tick(1);
      end
    end
  endtask

  initial begin
    pin = '1;
    ack = '0;
    tick(4);
    check("reset valid", o_valid, 0);
    check("reset data0", o_data[0], 0);
    reset = 1'b1;
    tick(10);

    // 8N1 basic word, latency from the pin and ack
    c0 = cyc;
    send(0, 'hA5, 1, 1, 0);
    line(0, 1, 20);
    check("t1 latency", rise_cyc[0] - c0, 156);
    check("t1 data", o_data[0], 'hA5);
    check("t1 flags", {o_perr[0], o_ferr[0], o_ovr[0]}, 0);
    pulse_ack(0);
    check("t1 valid after ack", o_valid[0], 0);

    // even parity: wrong then right parity bit
    send(1, 'h37, 0, 1, 0);
    line(1, 1, 20);
    check("t2 data", o_data[1], 'h37);
    check("t2 perr bad", o_perr[1], 1);
    pulse_ack(1);
    send(1, 'h37, 1, 1, 0);
    line(1, 1, 20);
    check("t2 perr good", o_perr[1], 0);
    pulse_ack(1);

    // 4-cycle glitch is rejected, then a real frame
    line(0, 0, 4);
    line(0, 1, 40);
    check("t3 no valid", o_valid[0], 0);
    send(0, 'h5A, 1, 1, 0);
    line(0, 1, 20);
    check("t3 data", o_data[0], 'h5A);
    pulse_ack(0);

    // stop bit low followed by a long low line
    send(0, 'h33, 1, 0, 0);
    line(0, 0, 40);
    check("t4 ferr", o_ferr[0], 1);
    pulse_ack(0);
    line(0, 1, 10);
    send(0, 'h11, 1, 1, 0);
    line(0, 1, 20);
    check("t4 data", o_data[0], 'h11);
    check("t4 ferr clear", o_ferr[0], 0);
    pulse_ack(0);

    // overrun, then ack coinciding with completion
    send(0, 'h01, 1, 1, 0);
    send(0, 'h02, 1, 1, 0);
    line(0, 1, 20);
    check("t5 data", o_data[0], 'h02);
    check("t5 overrun", o_ovr[0], 1);
    pulse_ack(0);
    check("t5 cleared", {o_valid[0], o_ovr[0]}, 0);
    send(0, 'h03, 1, 1, 0);
    line(0, 1, 10);
    fork
      send(0, 'h04, 1, 1, 0);
      begin tick(lat(0) - 1); pulse_ack(0); end
    join
    line(0, 1, 10);
    check("t5 ack+done overrun", o_ovr[0], 0);
    check("t5 ack+done data", o_data[0], 'h04);
    pulse_ack(0);

    // reset mid-frame with a word held; line low across release
    send(0, 'h66, 1, 1, 0);
    line(0, 0, 40);
    reset = 1'b0;
    tick(3);
    check("t6 reset outputs", {o_valid[0], o_data[0]}, 0);
    reset = 1'b1;
    line(0, 0, 20);
    check("t6 no frame", o_valid[0], 0);
    line(0, 1, 10);
    send(0, 'hFF, 1, 1, 0);
    line(0, 1, 20);
    check("t6 data", o_data[0], 'hFF);
    pulse_ack(0);

    // 9- and 5-bit words, two stop bits, x8, one corrupted sample per bit
    send(2, 'h1A5, 1, 3, 1);
    line(2, 1, 10);
    check("t7 data9", o_data[2], 'h1A5);
    pulse_ack(2);
    send(3, 'h15, 1, 3, 1);
    line(3, 1, 10);
    check("t7 data5", o_data[3], 'h15);
    pulse_ack(3);

    // random frames with random acks on every configuration
    for (int i = 0; i < NI; i++) begin
      rnd_done = 0;
      fork
        begin
          for (int f = 0; f < 12; f++) begin
            send(i, int'($urandom), $urandom_range(0, 3) != 0,
                 ($urandom_range(0, 3) == 0) ? int'($urandom) : -1,
                 (OSA[i] == 8) ? 1'b1 : 1'($urandom_range(0, 1)));
            line(i, 1, $urandom_range(2, 25));
          end
          rnd_done = 1;
        end
        while (!rnd_done) begin
          ack[i] = ($urandom_range(0, 5) == 0);
          tick(1);
        end
      join
      ack[i] = 1'b0;
      tick(5);
    end

    tick(20);
    check("pending words", evq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
